// File: rtl/nrisc_banked_regfile_pkg.sv
// nrisc_banked_regfile_pkg: shared register-map constants and depth-counter op encoding
package nrisc_banked_regfile_pkg;
  localparam int NRISC_TAM     = 16;
  localparam int NRISC_NREGS   = 16;
  localparam int NRISC_NGLOBAL = 8;
  localparam int NRISC_NBANKS  = 4;
  typedef enum logic [2:0] {OP_HOLD, OP_INC, OP_DEC, OP_OVF, OP_UNF} depth_op_e;
endpackage

// File: rtl/nrisc_banked_regfile_depth_ctr.sv
// nrisc_irq_depth_ctr: interrupt nesting depth counter with saturation and sticky over/underflow flags
//   clk, rst                 clock, sync active-high reset
//   irq_enter, irq_exit      one-cycle pulses from the interrupt controller
//   bank_cur                 current nesting depth (selects the register bank)
//   stack_ovf, stack_unf     sticky error flags, cleared only by rst
module nrisc_irq_depth_ctr import nrisc_banked_regfile_pkg::*; #(
  parameter int NBANKS = NRISC_NBANKS,
  localparam int BW = $clog2(NBANKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          irq_enter,
  input  logic          irq_exit,
  output logic [BW-1:0] bank_cur,
  output logic          stack_ovf,
  output logic          stack_unf
);
  localparam logic [BW-1:0] TOP = BW'(NBANKS - 1);
  depth_op_e op;
  always_comb
    op = (irq_enter && !irq_exit) ? ((bank_cur == TOP) ? OP_OVF : OP_INC) :
         (irq_exit && !irq_enter) ? ((bank_cur == '0) ? OP_UNF : OP_DEC) : OP_HOLD;
  always_ff @(posedge clk)
    if (rst) begin
      bank_cur  <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      if (op == OP_INC) bank_cur <= bank_cur + 1'b1;
      if (op == OP_DEC) bank_cur <= bank_cur - 1'b1;
      if (op == OP_OVF) stack_ovf <= 1'b1;
      if (op == OP_UNF) stack_unf <= 1'b1;
    end
endmodule

// File: rtl/nrisc_banked_regfile.sv
// nrisc_banked_regfile: NRISC register file, 2 async reads, 1 sync write, per-depth banked upper registers
//   REG_RF1/REG_RF2 -> REG_A/REG_B   combinational read ports (r0 = 0, r1 = REG_R1)
//   REG_RFD, REG_D, REG_Write         synchronous write port (r0/r1 writes ignored)
//   irq_enter/irq_exit -> bank_cur    nesting depth selecting the bank for regs NGLOBAL..NREGS-1
//   stack_ovf/stack_unf               sticky nesting errors
module nrisc_banked_regfile import nrisc_banked_regfile_pkg::*; #(
  parameter int TAM     = NRISC_TAM,
  parameter int NREGS   = NRISC_NREGS,
  parameter int NGLOBAL = NRISC_NGLOBAL,
  parameter int NBANKS  = NRISC_NBANKS,
  parameter bit BYPASS  = 1'b1,
  localparam int AW = $clog2(NREGS),
  localparam int BW = $clog2(NBANKS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [AW-1:0]  REG_RF1,
  input  logic [AW-1:0]  REG_RF2,
  input  logic [AW-1:0]  REG_RFD,
  input  logic [TAM-1:0] REG_D,
  input  logic           REG_Write,
  input  logic [TAM-1:0] REG_R1,
  output logic [TAM-1:0] REG_A,
  output logic [TAM-1:0] REG_B,
  input  logic           irq_enter,
  input  logic           irq_exit,
  output logic [BW-1:0]  bank_cur,
  output logic           stack_ovf,
  output logic           stack_unf
);
  localparam int NB = NREGS - NGLOBAL;
  localparam int GW = $clog2(NGLOBAL);
  localparam int KW = $clog2(NBANKS * NB);
  logic [TAM-1:0] glob_q [NGLOBAL-1:2];
  logic [TAM-1:0] bank_q [NBANKS*NB];
  logic [TAM-1:0] rd_a, rd_b;
  logic wr_ok;
  // Banked storage is laid out as {bank, offset}, offset = addr - NGLOBAL.
  function automatic logic [KW-1:0] kidx(input logic [BW-1:0] b, input logic [AW-1:0] a);
    return KW'(int'(b) * NB + int'(a) - NGLOBAL);
  endfunction
  nrisc_irq_depth_ctr #(.NBANKS(NBANKS)) u_depth (
    .clk(clk), .rst(rst), .irq_enter(irq_enter), .irq_exit(irq_exit),
    .bank_cur(bank_cur), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );
  assign wr_ok = REG_Write && REG_RFD >= AW'(2);
  assign rd_a = REG_RF1 == '0 ? '0 : REG_RF1 == AW'(1) ? REG_R1 :
                REG_RF1 < AW'(NGLOBAL) ? glob_q[REG_RF1[GW-1:0]] : bank_q[kidx(bank_cur, REG_RF1)];
  assign rd_b = REG_RF2 == '0 ? '0 : REG_RF2 == AW'(1) ? REG_R1 :
                REG_RF2 < AW'(NGLOBAL) ? glob_q[REG_RF2[GW-1:0]] : bank_q[kidx(bank_cur, REG_RF2)];
  assign REG_A = (BYPASS && wr_ok && REG_RF1 == REG_RFD) ? REG_D : rd_a;
  assign REG_B = (BYPASS && wr_ok && REG_RF2 == REG_RFD) ? REG_D : rd_b;
  // bank_cur here is the pre-edge depth, so a write alongside enter/exit lands in the old bank.
  always_ff @(posedge clk)
    if (rst) begin
      glob_q <= '{default: '0};
      bank_q <= '{default: '0};
    end else if (wr_ok) begin
      if (REG_RFD < AW'(NGLOBAL)) glob_q[REG_RFD[GW-1:0]] <= REG_D;
      else bank_q[kidx(bank_cur, REG_RFD)] <= REG_D;
    end
endmodule

// File: tb/tb_nrisc_banked_regfile.sv
// tb_nrisc_banked_regfile: directed self-checking bench for the banked register file
module tb_nrisc_banked_regfile;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] REG_RF1, REG_RF2, REG_RFD;
  logic [15:0] REG_D, REG_R1, REG_A, REG_B, nb_a, nb_b;
  logic REG_Write, irq_enter, irq_exit;
  logic [1:0] bank_cur, nb_bank;
  logic stack_ovf, stack_unf, nb_ovf, nb_unf;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nrisc_banked_regfile #(.BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .REG_RF1(REG_RF1), .REG_RF2(REG_RF2), .REG_RFD(REG_RFD),
    .REG_D(REG_D), .REG_Write(REG_Write), .REG_R1(REG_R1), .REG_A(REG_A), .REG_B(REG_B),
    .irq_enter(irq_enter), .irq_exit(irq_exit), .bank_cur(bank_cur),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );
  nrisc_banked_regfile #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .REG_RF1(REG_RF1), .REG_RF2(REG_RF2), .REG_RFD(REG_RFD),
    .REG_D(REG_D), .REG_Write(REG_Write), .REG_R1(REG_R1), .REG_A(nb_a), .REG_B(nb_b),
    .irq_enter(irq_enter), .irq_exit(irq_exit), .bank_cur(nb_bank),
    .stack_ovf(nb_ovf), .stack_unf(nb_unf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    REG_Write = 1'b1; REG_RFD = a; REG_D = d;
    tick;
    REG_Write = 1'b0;
  endtask

  task automatic pulse(input logic e, input logic x);
    irq_enter = e; irq_exit = x;
    tick;
    irq_enter = 1'b0; irq_exit = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int a = 2; a < 16; a++) begin
      REG_RF1 = 4'(a); REG_RF2 = 4'(a);
      #1;
      checks++;
      if (REG_A !== 16'h0 || REG_B !== 16'h0) begin
        errors++;
        $display("FAIL reset_read r%0d got A=%h B=%h exp 0000", a, REG_A, REG_B);
      end
    end
    checks++;
    if (bank_cur !== 2'd0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got bank=%0d ovf=%b unf=%b exp 0 0 0", bank_cur, stack_ovf, stack_unf);
    end
  endtask

  task automatic test_bank_persist;
    wr(4'd9, 16'h1234);
    pulse(1'b1, 1'b0);
    checks++;
    if (bank_cur !== 2'd1) begin
      errors++;
      $display("FAIL enter_depth got %0d exp 1", bank_cur);
    end
    REG_RF1 = 4'd9;
    #1;
    checks++;
    if (REG_A !== 16'h0) begin
      errors++;
      $display("FAIL bank1_fresh_r9 got %h exp 0000", REG_A);
    end
    wr(4'd9, 16'hBEEF);
    pulse(1'b0, 1'b1);
    REG_RF1 = 4'd9; REG_RF2 = 4'd9;
    #1;
    checks++;
    if (REG_A !== 16'h1234 || REG_B !== 16'h1234) begin
      errors++;
      $display("FAIL user_r9 got A=%h B=%h exp 1234", REG_A, REG_B);
    end
    pulse(1'b1, 1'b0);
    #1;
    checks++;
    if (REG_A !== 16'hBEEF) begin
      errors++;
      $display("FAIL isr_r9 got %h exp beef", REG_A);
    end
    pulse(1'b0, 1'b1);
  endtask

  task automatic test_global;
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    checks++;
    if (bank_cur !== 2'd2) begin
      errors++;
      $display("FAIL depth2 got %0d exp 2", bank_cur);
    end
    wr(4'd3, 16'h00AA);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    REG_RF1 = 4'd3; REG_RF2 = 4'd1; REG_R1 = 16'hC0DE;
    #1;
    checks++;
    if (REG_A !== 16'h00AA) begin
      errors++;
      $display("FAIL global_r3 got %h exp 00aa", REG_A);
    end
    checks++;
    if (REG_B !== 16'hC0DE) begin
      errors++;
      $display("FAIL read_r1 got %h exp c0de", REG_B);
    end
  endtask

  task automatic test_bypass;
    REG_Write = 1'b1; REG_RFD = 4'd5; REG_D = 16'h5A5A; REG_RF1 = 4'd5; REG_RF2 = 4'd5;
    #1;
    checks++;
    if (REG_A !== 16'h5A5A || REG_B !== 16'h5A5A) begin
      errors++;
      $display("FAIL bypass_hit got A=%h B=%h exp 5a5a", REG_A, REG_B);
    end
    checks++;
    if (nb_a !== 16'h0 || nb_b !== 16'h0) begin
      errors++;
      $display("FAIL nobypass_old got A=%h B=%h exp 0000", nb_a, nb_b);
    end
    tick;
    REG_Write = 1'b0;
    #1;
    checks++;
    if (nb_a !== 16'h5A5A) begin
      errors++;
      $display("FAIL nobypass_next got %h exp 5a5a", nb_a);
    end
    REG_Write = 1'b1; REG_RFD = 4'd0; REG_D = 16'hFFFF; REG_RF1 = 4'd0; REG_RF2 = 4'd1; REG_R1 = 16'h7777;
    #1;
    checks++;
    if (REG_A !== 16'h0) begin
      errors++;
      $display("FAIL bypass_r0 got %h exp 0000", REG_A);
    end
    tick;
    REG_RFD = 4'd1;
    #1;
    checks++;
    if (REG_B !== 16'h7777) begin
      errors++;
      $display("FAIL bypass_r1 got %h exp 7777", REG_B);
    end
    tick;
    REG_Write = 1'b0;
    #1;
    checks++;
    if (REG_A !== 16'h0 || REG_B !== 16'h7777) begin
      errors++;
      $display("FAIL r0r1_after_write got A=%h B=%h exp 0000 7777", REG_A, REG_B);
    end
  endtask

  task automatic test_depth;
    for (int i = 1; i <= 4; i++) begin
      pulse(1'b1, 1'b0);
      checks++;
      if (bank_cur !== 2'(i > 3 ? 3 : i) || stack_ovf !== (i == 4)) begin
        errors++;
        $display("FAIL enter_%0d got bank=%0d ovf=%b exp %0d %b", i, bank_cur, stack_ovf, i > 3 ? 3 : i, i == 4);
      end
    end
    pulse(1'b1, 1'b1);
    checks++;
    if (bank_cur !== 2'd3 || stack_ovf !== 1'b1 || stack_unf !== 1'b0) begin
      errors++;
      $display("FAIL both_at_top got bank=%0d ovf=%b unf=%b exp 3 1 0", bank_cur, stack_ovf, stack_unf);
    end
    for (int i = 2; i >= -1; i--) begin
      pulse(1'b0, 1'b1);
      checks++;
      if (bank_cur !== 2'(i < 0 ? 0 : i) || stack_unf !== (i < 0)) begin
        errors++;
        $display("FAIL exit_to_%0d got bank=%0d unf=%b exp %0d %b", i, bank_cur, stack_unf, i < 0 ? 0 : i, i < 0);
      end
    end
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    checks++;
    if (bank_cur !== 2'd1 || stack_ovf !== 1'b1 || stack_unf !== 1'b1) begin
      errors++;
      $display("FAIL both_mid got bank=%0d ovf=%b unf=%b exp 1 1 1", bank_cur, stack_ovf, stack_unf);
    end
  endtask

  task automatic test_write_with_exit;
    REG_Write = 1'b1; REG_RFD = 4'd12; REG_D = 16'h0C1C;
    pulse(1'b0, 1'b1);
    REG_Write = 1'b0; REG_RF1 = 4'd12;
    #1;
    checks++;
    if (REG_A !== 16'h0 || bank_cur !== 2'd0) begin
      errors++;
      $display("FAIL wr_exit_user got A=%h bank=%0d exp 0000 0", REG_A, bank_cur);
    end
    pulse(1'b1, 1'b0);
    #1;
    checks++;
    if (REG_A !== 16'h0C1C) begin
      errors++;
      $display("FAIL wr_exit_oldbank got %h exp 0c1c", REG_A);
    end
  endtask

  task automatic test_reset_priority;
    rst = 1'b1; REG_Write = 1'b1; REG_RFD = 4'd4; REG_D = 16'hAAAA; irq_enter = 1'b1;
    tick;
    rst = 1'b0; REG_Write = 1'b0; irq_enter = 1'b0;
    REG_RF1 = 4'd4; REG_RF2 = 4'd9;
    #1;
    checks++;
    if (REG_A !== 16'h0 || REG_B !== 16'h0) begin
      errors++;
      $display("FAIL rst_prio_regs got A=%h B=%h exp 0000", REG_A, REG_B);
    end
    checks++;
    if (bank_cur !== 2'd0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
      errors++;
      $display("FAIL rst_prio_state got bank=%0d ovf=%b unf=%b exp 0 0 0", bank_cur, stack_ovf, stack_unf);
    end
  endtask

  initial begin
    rst = 1'b0; REG_Write = 1'b0; irq_enter = 1'b0; irq_exit = 1'b0;
    REG_RF1 = '0; REG_RF2 = '0; REG_RFD = '0; REG_D = '0; REG_R1 = 16'h0001;
    #2;
    test_reset;
    test_bank_persist;
    test_global;
    test_bypass;
    test_depth;
    test_write_with_exit;
    test_reset_priority;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
